// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial unsigned adder/subtractor.
// One operand bit is folded through a 1-bit full adder per clock, LSB first.
// The full-width result is published only once, on entry to S_DONE.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; result holds the last completed value
// S_RUN  | one operand bit processed per rising edge, WIDTH edges total
// S_DONE | one-cycle result-valid pulse; start here chains a new op
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] result
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;
  logic             r_mode;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_result;

  logic             w_accept;
  logic             w_last;
  logic             w_cin;
  logic             w_bbit;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_all;

  // The carry register is cleared on acceptance, so bit 0 takes its
  // carry-in straight from the mode (1 for subtract: a + ~b + 1).
  assign w_cin     = (r_cnt == '0) ? r_mode : r_carry;
  assign w_bbit    = r_b[0] ^ r_mode;
  assign w_sum     = r_a[0] ^ w_bbit ^ w_cin;
  assign w_cout    = (r_a[0] & w_bbit) | (r_a[0] & w_cin) | (w_bbit & w_cin);
  assign w_sum_all = {w_sum, r_sum};
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_BIT);
  assign result    = r_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus busy/done/accept, all Moore except accept.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and serial datapath; operands shift right so bit 0
  // always feeds the adder, partial sum bits shift in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_mode  <= mode;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_all[WIDTH-1:1];
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result register: loaded only on the edge that processes the last bit.
  // Add: {0, carry}; subtract: both upper bits are the inverted carry
  // (no borrow -> non-negative, borrow -> sign-extended negative).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_last) begin
      r_result <= {r_mode & ~w_cout, w_cout ^ r_mode, w_sum_all};
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=4): directed table, chained ops,
// async reset abort, and randomized ops against an arithmetic model.
module tb_serial_addsub;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W+1:0] result;

  int           checks = 0;
  int           errors = 0;
  logic [W+1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W+1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[5];

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic m);
    int r;
    r = m ? (int'(x) - int'(y)) : (int'(x) + int'(y));
    return r[W+1:0];
  endfunction

  // Issue one operation (start pulsed for one cycle), scramble inputs after
  // acceptance, then check latency, busy length, result hold and value.
  // preset=1: caller is already at a negedge and wants start driven now.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input logic [W+1:0] exp, input string name, input bit preset);
    int busy_cnt;
    int lat;
    int hold_bad;
    busy_cnt = 0;
    lat      = 0;
    hold_bad = 0;
    if (!preset) @(negedge clk);
    a = x; b = y; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    mode  = 1'($urandom);
    for (int k = 1; k <= 3 * W; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (result !== last_res) hold_bad++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, W + 1);
    chk({name, "_busy_cycles"}, busy_cnt, W);
    chk({name, "_result_hidden"}, hold_bad, 0);
    chk({name, "_result"}, result, exp);
    last_res = exp;
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 1'b0);
    chk({name, "_result_hold"}, result, exp);
  endtask

  initial begin : main
    int pos[$];
    logic [W+1:0] res[$];
    int late;

    vecs[0] = '{4'b0110, 4'b1010, 1'b0, 6'b010000, "add_6_10"};
    vecs[1] = '{4'b0110, 4'b1010, 1'b1, 6'b111100, "sub_6_10"};
    vecs[2] = '{4'b0000, 4'b1100, 1'b1, 6'b110100, "sub_0_12"};
    vecs[3] = '{4'b1111, 4'b1111, 1'b0, 6'b011110, "add_15_15"};
    vecs[4] = '{4'b1011, 4'b0011, 1'b1, 6'b001000, "sub_11_3"};

    #12;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, '0);

    // Release reset and start on the same negedge: first edge accepts.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[0].a, vecs[0].b, vecs[0].m, vecs[0].exp, vecs[0].name, 1'b1);
    for (int i = 1; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, vecs[i].name, 1'b0);
    end

    // start held high across two chained operations.
    @(negedge clk);
    a = 4'b0010; b = 4'b0001; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'b0100; b = 4'b1001; mode = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (pos.size() > 0 && k == pos[0] + 1) begin
        a    = W'($urandom);
        b    = W'($urandom);
        mode = 1'($urandom);
      end
      if (done) begin
        pos.push_back(k);
        res.push_back(result);
      end
      @(negedge clk);
    end
    chk("b2b_two_pulses", (pos.size() >= 2) ? 1 : 0, 1);
    if (pos.size() >= 2) begin
      chk("b2b_gap", pos[1] - pos[0], 5);
      chk("b2b_first_latency", pos[0], W + 1);
      chk("b2b_res0", res[0], 6'b000011);
      chk("b2b_res1", res[1], 6'b111011);
    end
    start = 1'b0;
    rst_n = 1'b0;
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rm;
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      run_op(ra, rb, rm, model(ra, rb, rm), "rand", 1'b0);
    end

    // Asynchronous reset in the middle of RUN aborts the operation.
    run_op(4'b0101, 4'b0011, 1'b0, 6'd8, "pre_rst", 1'b0);
    @(negedge clk);
    a = 4'b1001; b = 4'b0100; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) late++;
    end
    chk("abort_no_done", late, 0);
    run_op(4'b1110, 4'b1101, 1'b0, 6'b011011, "after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
